// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB maintenance-op controller.
// Holds the op encodings, FSM state encoding and TLB sizing.
package tlb_op_ctrl_pkg;

    localparam int TLB_NUM   = 16;
    localparam int TLB_IDX_W = $clog2(TLB_NUM);

    typedef enum logic [1:0] {
        OP_TLBP  = 2'b00,
        OP_TLBR  = 2'b01,
        OP_TLBWI = 2'b10,
        OP_TLBWR = 2'b11
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_PWAIT   = 3'd2,
        ST_READ    = 3'd3,
        ST_RWAIT   = 3'd4,
        ST_WRITE   = 3'd5,
        ST_REFETCH = 3'd6
    } tlb_state_e;

    // Where fetch restarts after the op: branch target in a
    // delay slot, otherwise the next sequential instruction.
    function automatic logic [31:0] redirect_pc(
        input logic        bd,
        input logic [31:0] pc,
        input logic [31:0] target
    );
        return bd ? target : (pc + 32'd4);
    endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-op sequencer: tlbp/tlbr/tlbwi/tlbwr from M1,
// drives TLB ports and CP0 strobes, then redirects fetch.
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter  int TLBNUM = TLB_NUM,
    localparam int IDX_W  = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_type,
    input  logic [31:0]      op_pc,
    input  logic             op_bd,
    input  logic [31:0]      op_target,
    input  logic             m1s_ex,
    output logic             op_ready,
    output logic             stall,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_random,
    output logic             tlb_s_req,
    input  logic             tlb_s_found,
    input  logic [IDX_W-1:0] tlb_s_index,
    output logic [IDX_W-1:0] tlb_r_index,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic             inst_tlbp,
    output logic             inst_tlbr,
    output logic             refetch_valid,
    output logic [31:0]      refetch_pc,
    input  logic             refetch_ready
);

    tlb_state_e       state_q;
    tlb_state_e       state_d;
    tlb_op_e          op_q;
    logic             bd_q;
    logic [31:0]      pc_q;
    logic [IDX_W-1:0] rand_q;
    logic             accept;
    logic             unused_sink;

    // Search results and the bd flag go straight to CP0 / are
    // kept for debug only; they are not consumed by this block.
    assign unused_sink = ^{tlb_s_found, tlb_s_index, bd_q};

    // An op is taken only in IDLE and never while M1 excepts.
    assign accept = (state_q == ST_IDLE) & op_valid
                  & ~m1s_ex & ~reset;

    assign stall = (state_q != ST_IDLE) | (op_valid & ~m1s_ex);

    // The read port simply follows Index; only READ matters.
    assign tlb_r_index = cp0_index;
    assign tlb_w_index = (op_q == OP_TLBWR) ? rand_q : cp0_index;
    assign refetch_pc  = pc_q;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture op context at accept so later M1 changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_TLBP;
            bd_q   <= 1'b0;
            pc_q   <= 32'd0;
            rand_q <= '0;
        end else if (accept) begin
            op_q   <= tlb_op_e'(op_type);
            bd_q   <= op_bd;
            pc_q   <= redirect_pc(op_bd, op_pc, op_target);
            rand_q <= cp0_random;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_d       = state_q;
        op_ready      = 1'b0;
        tlb_s_req     = 1'b0;
        tlb_we        = 1'b0;
        inst_tlbp     = 1'b0;
        inst_tlbr     = 1'b0;
        refetch_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_ready = 1'b1;
                    unique case (tlb_op_e'(op_type))
                        OP_TLBP:  state_d = ST_SEARCH;
                        OP_TLBR:  state_d = ST_READ;
                        OP_TLBWI: state_d = ST_WRITE;
                        OP_TLBWR: state_d = ST_WRITE;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SEARCH: begin
                tlb_s_req = 1'b1;
                state_d   = ST_PWAIT;
            end
            ST_PWAIT: begin
                inst_tlbp = 1'b1;
                state_d   = ST_REFETCH;
            end
            ST_READ: begin
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                inst_tlbr = 1'b1;
                state_d   = ST_REFETCH;
            end
            ST_WRITE: begin
                tlb_we  = 1'b1;
                state_d = ST_REFETCH;
            end
            ST_REFETCH: begin
                refetch_valid = 1'b1;
                if (refetch_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl.
// Inputs change and outputs are sampled just after negedge.
module tb_tlb_op_ctrl;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] op_pc;
    logic        op_bd;
    logic [31:0] op_target;
    logic        m1s_ex;
    logic        op_ready;
    logic        stall;
    logic [3:0]  cp0_index;
    logic [3:0]  cp0_random;
    logic        tlb_s_req;
    logic        tlb_s_found;
    logic [3:0]  tlb_s_index;
    logic [3:0]  tlb_r_index;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic        inst_tlbp;
    logic        inst_tlbr;
    logic        refetch_valid;
    logic [31:0] refetch_pc;
    logic        refetch_ready;

    int checks;
    int errors;

    tlb_op_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_type       (op_type),
        .op_pc         (op_pc),
        .op_bd         (op_bd),
        .op_target     (op_target),
        .m1s_ex        (m1s_ex),
        .op_ready      (op_ready),
        .stall         (stall),
        .cp0_index     (cp0_index),
        .cp0_random    (cp0_random),
        .tlb_s_req     (tlb_s_req),
        .tlb_s_found   (tlb_s_found),
        .tlb_s_index   (tlb_s_index),
        .tlb_r_index   (tlb_r_index),
        .tlb_we        (tlb_we),
        .tlb_w_index   (tlb_w_index),
        .inst_tlbp     (inst_tlbp),
        .inst_tlbr     (inst_tlbr),
        .refetch_valid (refetch_valid),
        .refetch_pc    (refetch_pc),
        .refetch_ready (refetch_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Strobe vector {op_ready,s_req,we,tlbp,tlbr,refetch_valid}.
    function automatic logic [5:0] strobes();
        return {op_ready, tlb_s_req, tlb_we,
                inst_tlbp, inst_tlbr, refetch_valid};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        op_valid = 1'b1;
        op_type = 2'b10;
        next_cycle();
        checks++;
        if (strobes() !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want %b",
                     strobes(), 6'b0);
        end
        checks++;
        if (refetch_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h",
                     refetch_pc, 32'd0);
        end
        op_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
    endtask

    task automatic test_tlbwi();
        cp0_index = 4'd5;
        op_pc = 32'h8000_1000;
        op_bd = 1'b0;
        op_type = 2'b10;
        op_valid = 1'b1;
        #1;
        checks++;
        if ({op_ready, stall, tlb_we} !== 3'b110) begin
            errors++;
            $display("FAIL wi_accept: got %b want %b",
                     {op_ready, stall, tlb_we}, 3'b110);
        end
        next_cycle();
        op_valid = 1'b0;
        #1;
        checks++;
        if ({tlb_we, tlb_w_index, stall} !== {1'b1, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL wi_write: got we=%b idx=%0d st=%b want 1 5 1",
                     tlb_we, tlb_w_index, stall);
        end
        next_cycle();
        checks++;
        if ({refetch_valid, refetch_pc} !== {1'b1, 32'h8000_1004}) begin
            errors++;
            $display("FAIL wi_refetch: got v=%b pc=%h want 1 80001004",
                     refetch_valid, refetch_pc);
        end
        refetch_ready = 1'b1;
        next_cycle();
        refetch_ready = 1'b0;
        #1;
        checks++;
        if ({refetch_valid, stall, tlb_we} !== 3'b000) begin
            errors++;
            $display("FAIL wi_done: got %b want 000",
                     {refetch_valid, stall, tlb_we});
        end
    endtask

    task automatic test_tlbwr();
        cp0_index = 4'd2;
        cp0_random = 4'd9;
        op_pc = 32'h0000_2000;
        op_type = 2'b11;
        op_valid = 1'b1;
        next_cycle();
        op_valid = 1'b0;
        cp0_random = 4'd10;
        #1;
        checks++;
        if ({tlb_we, tlb_w_index} !== {1'b1, 4'd9}) begin
            errors++;
            $display("FAIL wr_index: got we=%b idx=%0d want 1 9",
                     tlb_we, tlb_w_index);
        end
        next_cycle();
        checks++;
        if ({tlb_we, refetch_valid, refetch_pc}
            !== {2'b01, 32'h0000_2004}) begin
            errors++;
            $display("FAIL wr_refetch: got we=%b v=%b pc=%h want 0 1 2004",
                     tlb_we, refetch_valid, refetch_pc);
        end
        refetch_ready = 1'b1;
        next_cycle();
        refetch_ready = 1'b0;
    endtask

    task automatic test_tlbp();
        logic [5:0] want [4];
        want[0] = 6'b100000;
        want[1] = 6'b010000;
        want[2] = 6'b000100;
        want[3] = 6'b000001;
        tlb_s_found = 1'b1;
        tlb_s_index = 4'd3;
        op_pc = 32'h8000_0040;
        op_type = 2'b00;
        op_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({strobes(), stall} !== {want[i], 1'b1}) begin
                errors++;
                $display("FAIL tlbp_c%0d: got %b want %b",
                         i, {strobes(), stall}, {want[i], 1'b1});
            end
            if (i == 3) refetch_ready = 1'b1;
            next_cycle();
            op_valid = 1'b0;
            #1;
        end
        refetch_ready = 1'b0;
        checks++;
        if ({stall, refetch_valid} !== 2'b00) begin
            errors++;
            $display("FAIL tlbp_done: got %b want 00",
                     {stall, refetch_valid});
        end
    endtask

    task automatic test_tlbr_bd();
        cp0_index = 4'd7;
        op_pc = 32'h8000_0100;
        op_bd = 1'b1;
        op_target = 32'hBFC0_0380;
        op_type = 2'b01;
        op_valid = 1'b1;
        next_cycle();
        op_valid = 1'b0;
        op_bd = 1'b0;
        op_target = 32'h0;
        #1;
        checks++;
        if ({tlb_r_index, inst_tlbr} !== {4'd7, 1'b0}) begin
            errors++;
            $display("FAIL tlbr_read: got idx=%0d tlbr=%b want 7 0",
                     tlb_r_index, inst_tlbr);
        end
        next_cycle();
        checks++;
        if ({inst_tlbr, refetch_valid} !== 2'b10) begin
            errors++;
            $display("FAIL tlbr_rwait: got %b want 10",
                     {inst_tlbr, refetch_valid});
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) refetch_ready = 1'b1;
            #1;
            checks++;
            if ({refetch_valid, refetch_pc}
                !== {1'b1, 32'hBFC0_0380}) begin
                errors++;
                $display("FAIL tlbr_hold%0d: got v=%b pc=%h want 1 bfc00380",
                         i, refetch_valid, refetch_pc);
            end
            next_cycle();
        end
        refetch_ready = 1'b0;
        #1;
        checks++;
        if (refetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL tlbr_done: got %b want 0", refetch_valid);
        end
    endtask

    task automatic test_m1s_ex();
        op_type = 2'b10;
        op_valid = 1'b1;
        m1s_ex = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({strobes(), stall} !== 7'b0) begin
                errors++;
                $display("FAIL m1s_ex_c%0d: got %b want 0",
                         i, {strobes(), stall});
            end
            next_cycle();
        end
        op_valid = 1'b0;
        m1s_ex = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid_write();
        cp0_index = 4'd4;
        op_pc = 32'h1234_0000;
        op_type = 2'b10;
        op_valid = 1'b1;
        next_cycle();
        op_valid = 1'b0;
        #1;
        checks++;
        if (tlb_we !== 1'b1) begin
            errors++;
            $display("FAIL rstw_pre: got we=%b want 1", tlb_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tlb_we, refetch_valid, stall, refetch_pc}
            !== {3'b000, 32'd0}) begin
            errors++;
            $display("FAIL rstw_now: got we=%b v=%b st=%b pc=%h want 0 0 0 0",
                     tlb_we, refetch_valid, stall, refetch_pc);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (strobes() !== 6'b0) begin
            errors++;
            $display("FAIL rstw_hold: got %b want 0", strobes());
        end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_pc_wrap();
        op_pc = 32'hFFFF_FFFC;
        op_bd = 1'b0;
        op_type = 2'b10;
        op_valid = 1'b1;
        next_cycle();
        op_valid = 1'b0;
        next_cycle();
        checks++;
        if ({refetch_valid, refetch_pc} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: got v=%b pc=%h want 1 00000000",
                     refetch_valid, refetch_pc);
        end
        refetch_ready = 1'b1;
        next_cycle();
        refetch_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] want [4];
        want[0] = 2'b10;
        want[1] = 2'b00;
        want[2] = 2'b01;
        want[3] = 2'b10;
        cp0_index = 4'd1;
        op_pc = 32'h0000_3000;
        op_type = 2'b10;
        op_valid = 1'b1;
        refetch_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({op_ready, refetch_valid} !== want[i]) begin
                errors++;
                $display("FAIL b2b_c%0d: got %b want %b",
                         i, {op_ready, refetch_valid}, want[i]);
            end
            next_cycle();
        end
        op_valid = 1'b0;
        next_cycle();
        next_cycle();
        refetch_ready = 1'b0;
        #1;
        checks++;
        if ({stall, refetch_valid} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_done: got %b want 00",
                     {stall, refetch_valid});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        op_valid = 1'b0;
        op_type = 2'b00;
        op_pc = 32'h0;
        op_bd = 1'b0;
        op_target = 32'h0;
        m1s_ex = 1'b0;
        cp0_index = 4'd0;
        cp0_random = 4'd0;
        tlb_s_found = 1'b0;
        tlb_s_index = 4'd0;
        refetch_ready = 1'b0;
        test_reset();
        test_tlbwi();
        test_tlbwr();
        test_tlbp();
        test_tlbr_bd();
        test_m1s_ex();
        test_reset_mid_write();
        test_pc_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
